pe_controller: RTL

Packet encoder controller for the USB transmit path of the bitcoin miner. It turns handshake requests (`transmit_ack`, `transmit_nack`) and result-ready requests (`host_ready`) from the packet decoder into byte streams: SYNC, PID, optional payload and CRC16. It hands these bytes to the bit-level serializer/NRZI encoder over a valid/ready handshake, then requests EOP. It sits between the decoder controller and the USB TX serializer.

---
 rtl/pe_controller.sv | 102 ++++++++++
 1 files changed

// File: rtl/pe_controller.sv
// pe_controller: USB TX packet encoder sequencing SYNC, PID, payload, CRC16 and EOP.
// Define PE_CRC16_EN to append the two CRC16 bytes to DATA packets.
module pe_controller #(
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       transmit_ack,
    input  logic       transmit_nack,
    input  logic       host_ready,
    input  logic       toggle_clr,
    input  logic [7:0] data_byte,
    input  logic       tx_ready,
    input  logic       eop_done,
    output logic [5:0] data_sel,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       eop_req,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam logic [3:0] IDLE = 4'd0, SYNC = 4'd1, PID = 4'd2, PAYLOAD = 4'd3, CRC_LO = 4'd4;
    localparam logic [3:0] CRC_HI = 4'd5, EOP = 4'd6, EOP_WAIT = 4'd7, DONE = 4'd8;
    localparam logic [1:0] K_ACK = 2'd0, K_NAK = 2'd1, K_DATA = 2'd2;
`ifdef PE_CRC16_EN
    localparam logic [3:0] AFTER_PAYLOAD = CRC_LO;
`else
    localparam logic [3:0] AFTER_PAYLOAD = EOP;
`endif
    logic [3:0] state, next;
    logic [1:0] kind;
    logic       p_ack, p_nack, p_data, toggle;
    logic [5:0] cnt;
    logic [7:0] pid;
    assign pid      = kind == K_ACK ? 8'hD2 : kind == K_NAK ? 8'h5A : toggle ? 8'h4B : 8'hC3;
    assign data_sel = cnt;
    assign tx_valid = state inside {SYNC, PID, PAYLOAD, CRC_LO, CRC_HI};
    assign eop_req  = state == EOP;
    assign tx_busy  = state != IDLE;
    assign tx_done  = state == DONE;
`ifdef PE_CRC16_EN
    logic [15:0] crc;
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) crc <= 16'hFFFF;
        else if (state == SYNC) crc <= 16'hFFFF;
        else if (state == PAYLOAD && tx_ready) crc <= crc_step(crc, data_byte);
`endif
    always_comb begin
        tx_data = 8'h00;
        case (state)
            SYNC:    tx_data = 8'h80;
            PID:     tx_data = pid;
            PAYLOAD: tx_data = data_byte;
`ifdef PE_CRC16_EN
            CRC_LO:  tx_data = ~crc[7:0];
            CRC_HI:  tx_data = ~crc[15:8];
`endif
            default: tx_data = 8'h00;
        endcase
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = (p_nack || p_ack || p_data) ? SYNC : IDLE;
            SYNC:     next = tx_ready ? PID : SYNC;
            PID:      next = tx_ready ? (kind == K_DATA ? PAYLOAD : EOP) : PID;
            PAYLOAD:  next = (tx_ready && cnt == 6'(PAYLOAD_BYTES - 1)) ? AFTER_PAYLOAD : PAYLOAD;
            CRC_LO:   next = tx_ready ? CRC_HI : CRC_LO;
            CRC_HI:   next = tx_ready ? EOP : CRC_HI;
            EOP:      next = EOP_WAIT;
            EOP_WAIT: next = eop_done ? DONE : EOP_WAIT;
            default:  next = IDLE;
        endcase
    end
    // A flag is consumed only when IDLE picks its packet; new pulses always re-set it
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state  <= IDLE;
            kind   <= K_ACK;
            p_ack  <= 1'b0;
            p_nack <= 1'b0;
            p_data <= 1'b0;
            toggle <= 1'b0;
            cnt    <= 6'd0;
        end else begin
            state  <= next;
            p_nack <= transmit_nack | (p_nack & (state != IDLE));
            p_ack  <= transmit_ack | (p_ack & !(state == IDLE && !p_nack));
            p_data <= host_ready | (p_data & !(state == IDLE && !p_nack && !p_ack));
            if (state == IDLE) kind <= p_nack ? K_NAK : p_ack ? K_ACK : K_DATA;
            if (state == SYNC) cnt <= 6'd0;
            else if (state == PAYLOAD && tx_ready) cnt <= cnt + 6'd1;
            if (toggle_clr) toggle <= 1'b0;
            else if (state == DONE && kind == K_DATA) toggle <= ~toggle;
        end
endmodule
